// File: rtl/nn_fixed_pkg.sv
// Fixed-point constants and shared types for the neuron datapath (x1000 scale).
// The sigmoid and back-propagation stages import the same definitions.
package nn_fixed_pkg;

    localparam int SCALE   = 1000;
    localparam int NET_MAX = 32767;
    localparam int NET_MIN = -32767;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCALE,
        S_DONE
    } state_e;

    typedef logic signed [15:0] net_t;

    // Full product width plus growth for n terms plus bias headroom, floor of 40.
    function automatic int acc_width(input int n);
        int w;
        w = 32 + $clog2(n) + 1;
        return (w < 40) ? 40 : w;
    endfunction

endpackage

// File: rtl/net_scale_sat.sv
// Combinational divide-by-SCALE (truncating toward zero) and symmetric clamp
// of the accumulator to the 16-bit Net range.
module net_scale_sat #(
    parameter int ACC_W = 40,
    parameter int SCALE = 1000
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [15:0]      net_o,
    output logic                    sat_o
);
    import nn_fixed_pkg::*;

    localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(SCALE);
    localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'(NET_MAX);
    localparam logic signed [ACC_W-1:0] Q_MIN   = ACC_W'(NET_MIN);

    // Lower bound is -32767 so a downstream |Net| can never overflow.
    function automatic logic [16:0] clamp_net(input logic signed [ACC_W-1:0] q);
        if (q > Q_MAX) begin
            return {1'b1, Q_MAX[15:0]};
        end else if (q < Q_MIN) begin
            return {1'b1, Q_MIN[15:0]};
        end
        return {1'b0, q[15:0]};
    endfunction

    logic signed [ACC_W-1:0] quot_d;
    logic [16:0]             clamp_d;

    always_comb begin
        quot_d  = acc_i / DIVISOR;
        clamp_d = clamp_net(quot_d);
        net_o   = clamp_d[15:0];
        sat_o   = clamp_d[16];
    end

endmodule

// File: rtl/neuron_net_accumulator.sv
// Streams N_INPUTS (x, w) pairs into a wide signed accumulator seeded with
// bias*SCALE, then scales and saturates to a 16-bit Net held until accepted.
module neuron_net_accumulator #(
    parameter int N_INPUTS = 4,
    parameter int SCALE    = nn_fixed_pkg::SCALE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] bias_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] w_in,
    output logic signed [15:0] net_out,
    output logic               net_valid,
    input  logic               out_ready,
    output logic               sat_flag,
    output logic               busy
);
    import nn_fixed_pkg::*;

    localparam int ACC_W = acc_width(N_INPUTS);
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SCALE_ACC = ACC_W'(SCALE);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] bias_acc_d;
    logic signed [31:0]      prod_d;
    net_t                    net_q;
    net_t                    net_d;
    logic                    sat_q;
    logic                    sat_d;

    assign prod_d     = x_in * w_in;
    assign acc_d      = acc_q + ACC_W'(prod_d);
    assign bias_acc_d = ACC_W'(bias_in) * SCALE_ACC;

    net_scale_sat #(
        .ACC_W (ACC_W),
        .SCALE (SCALE)
    ) u_scale_sat (
        .acc_i (acc_q),
        .net_o (net_d),
        .sat_o (sat_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            net_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= bias_acc_d;
                        cnt_q   <= '0;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= S_SCALE;
                        end
                    end
                end
                S_SCALE: begin
                    net_q   <= net_d;
                    sat_q   <= sat_d;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // A start arriving here is dropped; a new run needs IDLE.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign net_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign net_out   = net_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_neuron_net_accumulator.sv
// Directed bench for neuron_net_accumulator with hand-computed expected Nets.
module tb_neuron_net_accumulator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [15:0] bias_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] w_in;
    logic signed [15:0] net_out;
    logic               net_valid;
    logic               out_ready;
    logic               sat_flag;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    neuron_net_accumulator #(
        .N_INPUTS (4),
        .SCALE    (1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias_in   (bias_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .net_out   (net_out),
        .net_valid (net_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back evaluation with out_ready high; result expected after
    // the 5th edge following the start edge (cycle 6 counting start as 1).
    task automatic run_neuron(input string tag, input int bias,
                              input int x0, input int x1, input int x2, input int x3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int exp_net, input int exp_sat);
        int xs[4];
        int ws[4];
        int lat;
        xs = '{x0, x1, x2, x3};
        ws = '{w0, w1, w2, w3};
        bias_in = 16'(bias);
        start   = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_in_ready"}, in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            x_in     = 16'(xs[i]);
            w_in     = 16'(ws[i]);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        lat = 4;
        check({tag, "_scale_not_valid"}, net_valid, 0);
        while (!net_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency_edges"}, lat, 5);
        check({tag, "_net"}, net_out, exp_net);
        check({tag, "_sat"}, sat_flag, exp_sat);
        check({tag, "_busy"}, busy, 1);
        tick();
        check({tag, "_released"}, net_valid, 0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        start     = 1'b0;
        bias_in   = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        w_in      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_net_out", net_out, 0);
        check("rst_net_valid", net_valid, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 0);

        // 500000 + 1000000 - 500000 = 1,000,000
        run_neuron("nominal", 0, 1000, 2000, -500, 0, 500, 500, 1000, 0, 1000, 0);
        // 250,000 + 999 - 999
        run_neuron("bias", 250, 1, -1, 0, 0, 999, 999, 0, 0, 250, 0);
        // -999 / 1000 truncates toward zero
        run_neuron("trunc_neg", 0, -1, 0, 0, 0, 999, 0, 0, 0, 0, 0);
        // 32,767,000 exactly: largest unsaturated Net
        run_neuron("edge_max", 32767, 0, 0, 0, 0, 0, 0, 0, 0, 32767, 0);
        // -32,767,999 -> -32767, still in range
        run_neuron("edge_min", -32767, -1, 0, 0, 0, 999, 0, 0, 0, -32767, 0);
        // -32,768,000 -> -32768 must clamp to -32767
        run_neuron("bias_min", -32768, 0, 0, 0, 0, 0, 0, 0, 0, -32767, 1);
        // 4 * 1,073,676,289 = 4,294,705,156
        run_neuron("sat_pos", 0, 32767, 32767, 32767, 32767,
                   32767, 32767, 32767, 32767, 32767, 1);

        // Stalled input (1,0,0 pattern) and held output.
        bias_in = '0;
        start   = 1'b1;
        tick();
        out_ready = 1'b0;
        begin
            int xs[4];
            int ws[4];
            xs = '{1000, 2000, -500, 0};
            ws = '{500, 500, 1000, 0};
            for (int i = 0; i < 4; i++) begin
                x_in     = 16'(xs[i]);
                w_in     = 16'(ws[i]);
                in_valid = 1'b1;
                tick();
                in_valid = 1'b0;
                x_in     = 16'sd7;
                w_in     = 16'sd7;
                tick();
                tick();
            end
        end
        start = 1'b0;
        lat = 0;
        while (!net_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_valid", net_valid, 1);
        check("bp_net", net_out, 1000);
        check("bp_sat", sat_flag, 0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", net_valid, 1);
            check("bp_hold_net", net_out, 1000);
        end
        out_ready = 1'b1;
        tick();
        check("bp_done_start_ignored", busy, 0);
        start = 1'b0;
        tick();
        check("bp_idle_stays", busy, 0);

        // -1,073,709,056 * 4 = -4,294,836,224 -> clamp to -32767
        run_neuron("sat_neg", 0, -32768, -32768, -32768, -32768,
                   32767, 32767, 32767, 32767, -32767, 1);

        // Reset in the middle of an accumulation.
        bias_in = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x_in     = 16'sd32767;
            w_in     = 16'sd32767;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("mid_rst_net_out", net_out, 0);
        check("mid_rst_net_valid", net_valid, 0);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        run_neuron("post_rst", 0, 1000, 0, 0, 0, 3000, 0, 0, 0, 3000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
